lpc_record_packer: RTL and testbench

LPC_RECORD_PACKER -- requirements
Module: lpc_record_packer

---
 rtl/lpc_record_packer_if.sv | 41 ++++
 rtl/lpc_record_packer.sv | 151 +++++++++++++++
 tb/tb_lpc_record_packer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_record_packer_if.sv
// Bus bundle for lpc_record_packer: upstream LPC transaction fields,
// the outgoing byte stream, status flags and serializer debug visibility.
//
// Handshake: out_byte is meaningful only while out_valid=1. A byte moves on
// every rising lpc_clock edge where out_valid=1 and out_ready=1. While
// out_valid=1 and out_ready=0, out_byte holds stable until accepted.
interface lpc_record_packer_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_mode;
    logic          in_direction;
    logic [31:0]   in_addr;
    logic [7:0]    in_data;
    logic          in_latch;

    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready;

    logic          overflow;
    logic [7:0]    drop_count;
    logic [LW-1:0] fifo_level;

    // Serializer state (0 = IDLE, 1 = SEND) and current byte index
    logic          dbg_state;
    logic [1:0]    dbg_idx;

    modport master (
        output in_mode, in_direction, in_addr, in_data, in_latch, out_ready,
        input  out_byte, out_valid, overflow, drop_count, fifo_level,
        input  dbg_state, dbg_idx
    );

    modport slave (
        input  in_mode, in_direction, in_addr, in_data, in_latch, out_ready,
        output out_byte, out_valid, overflow, drop_count, fifo_level,
        output dbg_state, dbg_idx
    );
endinterface

// File: rtl/lpc_record_packer.sv
// Captures completed LPC transactions on the rising edge of in_latch, queues
// them as 26-bit records in a FIFO and serializes each record as four bytes:
// {4'hA, 2'b00, mode, dir}, addr[15:8], addr[7:0], data.
module lpc_record_packer #(
    parameter int DEPTH = 8
) (
    input logic              lpc_clock,
    input logic              lpc_reset,
    lpc_record_packer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    // Record layout: [25] mode, [24] direction, [23:8] addr[15:0], [7:0] data
    logic [25:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;

    logic          prev_latch_q;
    logic          capture, accept, reject, pop;
    logic [25:0]   wr_rec;

    ser_state_t    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [25:0]   hold_q;
    logic [7:0]    sel_byte;
    logic          out_valid_c;
    logic [7:0]    out_byte_c;

    logic          overflow_q;
    logic [7:0]    drop_q;

    // Upper address bits are not part of the record
    logic          unused_addr_hi;
    assign unused_addr_hi = ^bus.in_addr[31:16];

    assign capture = bus.in_latch & ~prev_latch_q;
    assign accept  = capture & ((level_q != FULL_LEVEL) | pop);
    assign reject  = capture & ~accept;
    assign wr_rec  = {bus.in_mode, bus.in_direction, bus.in_addr[15:0], bus.in_data};

    // Edge detector history; resets high so a latch already high is ignored
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) prev_latch_q <= 1'b1;
        else            prev_latch_q <= bus.in_latch;
    end

    // FIFO storage; contents are don't-care when the level says empty
    always_ff @(posedge lpc_clock) begin
        if (accept) mem[wr_ptr_q] <= wr_rec;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({accept, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Drop bookkeeping: sticky overflow and saturating drop counter
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else if (reject) begin
            overflow_q <= 1'b1;
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'h01;
        end
    end

    // Byte selection from the hold register by index
    always_comb begin
        sel_byte = 8'h00;
        case (idx_q)
            2'd0: sel_byte = {4'hA, 2'b00, hold_q[25], hold_q[24]};
            2'd1: sel_byte = hold_q[23:16];
            2'd2: sel_byte = hold_q[15:8];
            2'd3: sel_byte = hold_q[7:0];
            default: sel_byte = 8'h00;
        endcase
    end

    // Serializer next state, pop request and stream outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pop         = 1'b0;
        out_valid_c = 1'b0;
        out_byte_c  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                out_valid_c = 1'b1;
                out_byte_c  = sel_byte;
                if (bus.out_ready) begin
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        // Chain straight into the next record when one is queued
                        if (level_q != '0) pop = 1'b1;
                        else               state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Serializer state, index and hold register
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (pop) hold_q <= mem[rd_ptr_q];
        end
    end

    assign bus.out_valid  = out_valid_c;
    assign bus.out_byte   = out_byte_c;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;
    assign bus.fifo_level = level_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_idx    = idx_q;
endmodule

// File: tb/tb_lpc_record_packer.sv
// Directed bench for lpc_record_packer: table of single transactions with
// hand-computed byte streams, then sequences for back-pressure, overflow,
// full-with-pop, held latch and reset mid-record.
module tb_lpc_record_packer;
    logic lpc_clock;
    logic lpc_reset;

    lpc_record_packer_if #(.DEPTH(8)) bus ();

    lpc_record_packer #(.DEPTH(8)) dut (
        .lpc_clock (lpc_clock),
        .lpc_reset (lpc_reset),
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic        mode;
        logic        dir;
        logic [31:0] addr;
        logic [7:0]  data;
        logic [31:0] bytes;   // byte0 in [31:24] ... byte3 in [7:0]
    } vec_t;

    vec_t vecs [4];

    // Clock
    initial begin
        lpc_clock = 1'b0;
        forever #5 lpc_clock = ~lpc_clock;
    end

    task automatic tick();
        @(posedge lpc_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic sb_check(input string name);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got byte 0x%0h expected nothing (queue empty)", name, bus.out_byte);
        end else begin
            check(name, {24'h0, bus.out_byte}, {24'h0, exp_q.pop_front()});
        end
    endtask

    task automatic push_rec(input logic mode, input logic dir, input logic [15:0] addr, input logic [7:0] data);
        exp_q.push_back({4'hA, 2'b00, mode, dir});
        exp_q.push_back(addr[15:8]);
        exp_q.push_back(addr[7:0]);
        exp_q.push_back(data);
    endtask

    // One latch pulse: capture on the first edge, latch low on the second
    task automatic capture(input logic mode, input logic dir, input logic [31:0] addr, input logic [7:0] data);
        bus.in_mode      = mode;
        bus.in_direction = dir;
        bus.in_addr      = addr;
        bus.in_data      = data;
        bus.in_latch     = 1'b1;
        tick();
        bus.in_latch     = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [7:0]  d;

        vecs[0] = '{mode: 1'b1, dir: 1'b1, addr: 32'h0000_0080, data: 8'h5A, bytes: 32'hA3_00_80_5A};
        vecs[1] = '{mode: 1'b0, dir: 1'b0, addr: 32'h0000_1234, data: 8'hC3, bytes: 32'hA0_12_34_C3};
        vecs[2] = '{mode: 1'b1, dir: 1'b0, addr: 32'hFFFF_BEEF, data: 8'h00, bytes: 32'hA2_BE_EF_00};
        vecs[3] = '{mode: 1'b0, dir: 1'b1, addr: 32'hABCD_0001, data: 8'hFF, bytes: 32'hA1_00_01_FF};

        // Reset
        lpc_reset        = 1'b0;
        bus.in_mode      = 1'b0;
        bus.in_direction = 1'b0;
        bus.in_addr      = 32'h0;
        bus.in_data      = 8'h0;
        bus.in_latch     = 1'b0;
        bus.out_ready    = 1'b1;
        #3;
        check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_byte", {24'h0, bus.out_byte}, 32'h0);
        check("rst_level", {28'h0, bus.fifo_level}, 32'h0);
        check("rst_overflow", {31'h0, bus.overflow}, 32'h0);
        check("rst_drop", {24'h0, bus.drop_count}, 32'h0);
        check("rst_state", {31'h0, bus.dbg_state}, 32'h0);
        check("rst_idx", {30'h0, bus.dbg_idx}, 32'h0);
        repeat (2) @(posedge lpc_clock);
        @(negedge lpc_clock);
        lpc_reset = 1'b1;
        tick();

        // Table of single transactions with out_ready=1
        for (int v = 0; v < 4; v++) begin
            bus.in_mode      = vecs[v].mode;
            bus.in_direction = vecs[v].dir;
            bus.in_addr      = vecs[v].addr;
            bus.in_data      = vecs[v].data;
            bus.in_latch     = 1'b1;
            tick();
            check($sformatf("vec%0d_cap_valid", v), {31'h0, bus.out_valid}, 32'h0);
            check($sformatf("vec%0d_cap_level", v), {28'h0, bus.fifo_level}, 32'h1);
            bus.in_latch = 1'b0;
            for (int b = 0; b < 4; b++) begin
                tick();
                check($sformatf("vec%0d_b%0d_valid", v, b), {31'h0, bus.out_valid}, 32'h1);
                check($sformatf("vec%0d_b%0d_byte", v, b), {24'h0, bus.out_byte}, {24'h0, vecs[v].bytes[31-8*b -: 8]});
            end
            tick();
            check($sformatf("vec%0d_end_valid", v), {31'h0, bus.out_valid}, 32'h0);
            check($sformatf("vec%0d_end_level", v), {28'h0, bus.fifo_level}, 32'h0);
        end

        // Back-pressure during idx 1
        bus.in_mode = 1'b1; bus.in_direction = 1'b1; bus.in_addr = 32'h80; bus.in_data = 8'h5A;
        bus.in_latch = 1'b1;
        tick();
        bus.in_latch = 1'b0;
        tick();
        check("bp_b0", {24'h0, bus.out_byte}, 32'hA3);
        tick();
        check("bp_b1", {24'h0, bus.out_byte}, 32'h00);
        check("bp_idx1", {30'h0, bus.dbg_idx}, 32'h1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_valid", {31'h0, bus.out_valid}, 32'h1);
            check("bp_hold_byte", {24'h0, bus.out_byte}, 32'h00);
            check("bp_hold_idx", {30'h0, bus.dbg_idx}, 32'h1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_b2", {24'h0, bus.out_byte}, 32'h80);
        tick();
        check("bp_b3", {24'h0, bus.out_byte}, 32'h5A);
        tick();
        check("bp_end_valid", {31'h0, bus.out_valid}, 32'h0);

        // Overflow: 10 captures while stalled, the last one is dropped
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = 32'h0000_0100 + 32'(i);
            d = 8'h10 + 8'(i);
            capture(i[0], i[1], a, d);
            if (i < 9) push_rec(i[0], i[1], a[15:0], d);
        end
        check("ovf_level", {28'h0, bus.fifo_level}, 32'h8);
        check("ovf_flag", {31'h0, bus.overflow}, 32'h1);
        check("ovf_drop", {24'h0, bus.drop_count}, 32'h1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 36; k++) begin
            check("ovf_drain_valid", {31'h0, bus.out_valid}, 32'h1);
            sb_check("ovf_drain_byte");
            tick();
        end
        check("ovf_drain_end", {31'h0, bus.out_valid}, 32'h0);
        check("ovf_drain_q", exp_q.size(), 32'h0);

        // Full FIFO with a capture on the same edge as the idx 3 transfer
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            a = 32'h0000_0200 + 32'(i);
            d = 8'h20 + 8'(i);
            capture(i[1], i[0], a, d);
            push_rec(i[1], i[0], a[15:0], d);
        end
        push_rec(1'b1, 1'b0, 16'h2FF0, 8'hEE);
        check("full_level", {28'h0, bus.fifo_level}, 32'h8);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb_check("full_rec0_byte");
            tick();
        end
        check("full_idx3", {30'h0, bus.dbg_idx}, 32'h3);
        sb_check("full_rec0_byte3");
        bus.in_mode = 1'b1; bus.in_direction = 1'b0; bus.in_addr = 32'h2FF0; bus.in_data = 8'hEE;
        bus.in_latch = 1'b1;
        tick();
        bus.in_latch = 1'b0;
        check("full_pop_level", {28'h0, bus.fifo_level}, 32'h8);
        check("full_pop_drop", {24'h0, bus.drop_count}, 32'h1);
        check("full_pop_idx", {30'h0, bus.dbg_idx}, 32'h0);
        for (int k = 0; k < 36; k++) begin
            check("full_drain_valid", {31'h0, bus.out_valid}, 32'h1);
            sb_check("full_drain_byte");
            tick();
        end
        check("full_drain_end", {31'h0, bus.out_valid}, 32'h0);
        check("full_drain_q", exp_q.size(), 32'h0);

        // Latch held high for 20 cycles yields one record
        bus.in_mode = 1'b0; bus.in_direction = 1'b1; bus.in_addr = 32'h0000_3C3C; bus.in_data = 8'h77;
        push_rec(1'b0, 1'b1, 16'h3C3C, 8'h77);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            bus.in_latch = (k < 20);
            if (bus.out_valid) begin
                n++;
                sb_check("held_byte");
            end
            tick();
        end
        check("held_count", n, 32'd4);
        check("held_q", exp_q.size(), 32'h0);

        // Reset during idx 2 with three records queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) capture(1'b1, 1'b1, 32'h0000_4000 + 32'(i), 8'h40 + 8'(i));
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("mid_idx2", {30'h0, bus.dbg_idx}, 32'h2);
        check("mid_level3", {28'h0, bus.fifo_level}, 32'h3);
        bus.in_latch = 1'b1;
        #2;
        lpc_reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, bus.out_valid}, 32'h0);
        check("mid_rst_level", {28'h0, bus.fifo_level}, 32'h0);
        check("mid_rst_byte", {24'h0, bus.out_byte}, 32'h0);
        check("mid_rst_ovf", {31'h0, bus.overflow}, 32'h0);
        check("mid_rst_drop", {24'h0, bus.drop_count}, 32'h0);
        repeat (3) @(posedge lpc_clock);
        @(negedge lpc_clock);
        lpc_reset = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.out_valid) n++;
        end
        check("mid_release_count", n, 32'd0);
        check("mid_release_level", {28'h0, bus.fifo_level}, 32'h0);
        bus.in_latch = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
